// File: rtl/display_pkg.sv
// Constants shared by the result display producer and the display controller's
// shifter, plus the transmit FSM state encoding.
package display_pkg;

  localparam int NUM_WORDS = 18;
  localparam int WORD_W    = 16;
  localparam int ADDR_W    = 5;
  localparam int PACE_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    LAST = 2'd3
  } tx_state_e;

endpackage

// File: rtl/result_buffer.sv
// NUM_WORDS x WORD_W register file: synchronous write, combinational read,
// asynchronous clear to zero.
module result_buffer
  import display_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] words [NUM_WORDS];

  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      logic [WORD_W-1:0] word_reg;

      // Full-width address compare, so indices >= NUM_WORDS never alias an entry.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          word_reg <= '0;
        end else if (wr_en && (wr_addr == ADDR_W'(gi))) begin
          word_reg <= wr_data;
        end
      end

      assign words[gi] = word_reg;
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    if (rd_addr < ADDR_W'(NUM_WORDS)) begin
      rd_data = words[rd_addr];
    end
  end

endmodule

// File: rtl/result_stream_tx.sv
// Streams the result buffer to the display serial-in port, last word first, so
// word 0 ends up in the display's first slot after a full frame.
module result_stream_tx
  import display_pkg::*;
#(
  parameter int PACE = 4
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] data_out,
  output logic              en_out
);

  tx_state_e         state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [PACE_W-1:0] pace_reg, pace_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              en_reg, en_next;
  logic [WORD_W-1:0] data_reg, data_next;
  logic [WORD_W-1:0] rd_data;

  result_buffer u_buffer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx_reg),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      pace_reg  <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      en_reg    <= 1'b0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      pace_reg  <= pace_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      en_reg    <= en_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = SEND;
      SEND: begin
        if (idx_reg == '0) begin
          state_next = LAST;
        end else if (PACE > 1) begin
          state_next = GAP;
        end else begin
          state_next = SEND;
        end
      end
      GAP:  if (pace_reg == '0) state_next = SEND;
      LAST: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The buffer read in SEND sees the pre-edge contents, so a same-edge write
  // to the word being emitted only shows up in the next frame.
  always_comb begin
    idx_next  = idx_reg;
    pace_next = pace_reg;
    busy_next = busy_reg;
    done_next = 1'b0;
    en_next   = 1'b0;
    data_next = data_reg;
    case (state_reg)
      IDLE: begin
        if (start) idx_next = ADDR_W'(NUM_WORDS - 1);
      end
      SEND: begin
        data_next = rd_data;
        en_next   = 1'b1;
        busy_next = 1'b1;
        if (idx_reg != '0) begin
          idx_next  = idx_reg - 1'b1;
          // GAP lasts PACE-1 cycles: it exits when the counter reaches zero.
          pace_next = PACE_W'((PACE > 1) ? (PACE - 2) : 0);
        end
      end
      GAP: begin
        if (pace_reg != '0) pace_next = pace_reg - 1'b1;
      end
      LAST: begin
        done_next = 1'b1;
        busy_next = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign en_out   = en_reg;
  assign data_out = data_reg;

endmodule

// File: tb/tb_result_stream_tx.sv
// Bench for result_stream_tx: a PACE=4 and a PACE=1 instance share the write
// bus; a word-array model predicts each frame's words, timing and shift result.
module tb_result_stream_tx;
  import display_pkg::*;

  typedef logic [WORD_W-1:0] frame_t [NUM_WORDS];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [WORD_W-1:0] wr_data = '0;
  logic              start4 = 1'b0, start1 = 1'b0;
  logic              busy4, done4, en4, busy1, done1, en1;
  logic [WORD_W-1:0] data4, data1;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  frame_t ref_buf;

  logic [WORD_W-1:0] q4_data[$], q1_data[$];
  int q4_cyc[$], q1_cyc[$], d4_cyc[$], d1_cyc[$];
  int b4 = 0, b1 = 0;

  always #10 clk = ~clk;

  result_stream_tx #(.PACE(4)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start4), .busy(busy4), .done(done4), .data_out(data4), .en_out(en4)
  );

  result_stream_tx #(.PACE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start1), .busy(busy1), .done(done1), .data_out(data1), .en_out(en1)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (en4) begin q4_data.push_back(data4); q4_cyc.push_back(cyc); end
    if (en1) begin q1_data.push_back(data1); q1_cyc.push_back(cyc); end
    if (done4) d4_cyc.push_back(cyc);
    if (done1) d1_cyc.push_back(cyc);
    if (busy4) b4 <= b4 + 1;
    if (busy1) b1 <= b1 + 1;
  end

  task automatic wr(input int a, input logic [WORD_W-1:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if (a < NUM_WORDS) ref_buf[a] = d;
    $display("write addr=%0d data=%04h", a, d);
  endtask

  task automatic get_bases(input bit sel, output int pb, output int db, output int bb);
    pb = sel ? q1_cyc.size() : q4_cyc.size();
    db = sel ? d1_cyc.size() : d4_cyc.size();
    bb = sel ? b1 : b4;
  endtask

  task automatic start_frame(input bit sel, output int k);
    @(posedge clk); #1;
    if (sel) start1 = 1'b1; else start4 = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    start4 = 1'b0; start1 = 1'b0;
  endtask

  // Expected: word NUM_WORDS-1-i on pulse i at cycle k+1+i*pace, done one cycle
  // after the last pulse, busy for (NUM_WORDS-1)*pace+1 cycles.
  task automatic check_frame(input bit sel, input int pace, input int k, input frame_t exp,
                             input int pb, input int db, input int bb, input string tag);
    logic [WORD_W-1:0] dq[$];
    int cq[$], dn[$];
    int t, np, bcnt;
    bit got;
    logic [NUM_WORDS*WORD_W-1:0] sipo, exp_sipo;
    got = 1'b0;
    t = 0;
    while (t < NUM_WORDS * pace + 40 && !got) begin
      @(negedge clk); #1;
      got = ((sel ? d1_cyc.size() : d4_cyc.size()) > db);
      t++;
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL %s done_timeout: no done within %0d cycles", tag, t);
      return;
    end
    if (sel) begin dq = q1_data; cq = q1_cyc; dn = d1_cyc; bcnt = b1 - bb; end
    else     begin dq = q4_data; cq = q4_cyc; dn = d4_cyc; bcnt = b4 - bb; end
    np = cq.size() - pb;
    n_vec++;
    if (np != NUM_WORDS) begin
      n_err++;
      $display("FAIL %s pulse_count: got %0d want %0d", tag, np, NUM_WORDS);
    end
    if (np > NUM_WORDS) np = NUM_WORDS;
    sipo = '0;
    for (int i = 0; i < np; i++) begin
      n_vec++;
      if (dq[pb+i] !== exp[NUM_WORDS-1-i]) begin
        n_err++;
        $display("FAIL %s word%0d: got %04h want %04h", tag, i, dq[pb+i], exp[NUM_WORDS-1-i]);
      end
      n_vec++;
      if (cq[pb+i] != k + 1 + i * pace) begin
        n_err++;
        $display("FAIL %s pulse%0d_cycle: got %0d want %0d", tag, i, cq[pb+i], k + 1 + i * pace);
      end
      sipo = {sipo[(NUM_WORDS-1)*WORD_W-1:0], dq[pb+i]};
    end
    for (int i = 0; i < NUM_WORDS; i++) exp_sipo[i*WORD_W +: WORD_W] = exp[i];
    n_vec++;
    if (dn[db] != k + 1 + (NUM_WORDS - 1) * pace + 1) begin
      n_err++;
      $display("FAIL %s done_cycle: got %0d want %0d", tag, dn[db], k + 1 + (NUM_WORDS - 1) * pace + 1);
    end
    n_vec++;
    if (bcnt != (NUM_WORDS - 1) * pace + 1) begin
      n_err++;
      $display("FAIL %s busy_cycles: got %0d want %0d", tag, bcnt, (NUM_WORDS - 1) * pace + 1);
    end
    n_vec++;
    if (sipo !== exp_sipo) begin
      n_err++;
      $display("FAIL %s sipo: slot0 got %04h want %04h, slot17 got %04h want %04h", tag,
               sipo[15:0], exp_sipo[15:0], sipo[287:272], exp_sipo[287:272]);
    end
    $display("frame %s: pace=%0d start_edge=%0d pulses=%0d busy=%0d", tag, pace, k, cq.size() - pb, bcnt);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({busy4, done4, en4, data4, busy1, done1, en1, data1} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got %0h want 0", {busy4, done4, en4, data4, busy1, done1, en1, data1});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({busy4, done4, en4, data4} !== '0) begin
      n_err++;
      $display("FAIL post_reset_idle: got %0h want 0", {busy4, done4, en4, data4});
    end
    $display("reset released");
  endtask

  task automatic test_zero_frame();
    int pb, db, bb, k;
    get_bases(1'b0, pb, db, bb);
    start_frame(1'b0, k);
    check_frame(1'b0, 4, k, ref_buf, pb, db, bb, "zero");
  endtask

  task automatic test_ramp_frame();
    int pb, db, bb, k;
    for (int i = 0; i < NUM_WORDS; i++) wr(i, 16'(16'h1000 + i));
    get_bases(1'b0, pb, db, bb);
    start_frame(1'b0, k);
    check_frame(1'b0, 4, k, ref_buf, pb, db, bb, "ramp");
  endtask

  task automatic test_pace1();
    int pb, db, bb, k;
    get_bases(1'b1, pb, db, bb);
    start_frame(1'b1, k);
    check_frame(1'b1, 1, k, ref_buf, pb, db, bb, "pace1");
  endtask

  task automatic test_random();
    int pb, db, bb, k;
    for (int i = 0; i < 40; i++) wr(int'($urandom_range(0, 31)), 16'($urandom));
    get_bases(1'b0, pb, db, bb);
    start_frame(1'b0, k);
    check_frame(1'b0, 4, k, ref_buf, pb, db, bb, "random4");
    get_bases(1'b1, pb, db, bb);
    start_frame(1'b1, k);
    check_frame(1'b1, 1, k, ref_buf, pb, db, bb, "random1");
  endtask

  task automatic test_restart();
    int pb, db, bb, k, k2, t;
    // Re-pulses on the 5th pulse and on the edge that raises done are ignored.
    get_bases(1'b0, pb, db, bb);
    start_frame(1'b0, k);
    t = 0;
    while (q4_cyc.size() < pb + 5 && t < 200) begin @(negedge clk); #1; t++; end
    start4 = 1'b1; @(posedge clk); #1; start4 = 1'b0;
    t = 0;
    while (q4_cyc.size() < pb + NUM_WORDS && t < 200) begin @(negedge clk); #1; t++; end
    start4 = 1'b1; @(posedge clk); #1; start4 = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_vec++;
    if (q4_cyc.size() - pb != NUM_WORDS || d4_cyc.size() - db != 1 || b4 - bb != 69) begin
      n_err++;
      $display("FAIL restart_ignored: pulses=%0d dones=%0d busy=%0d want 18/1/69",
               q4_cyc.size() - pb, d4_cyc.size() - db, b4 - bb);
    end
    $display("restart pulses ignored: pulses=%0d", q4_cyc.size() - pb);
    // Start held through the done cycle launches the next frame one edge later.
    get_bases(1'b0, pb, db, bb);
    start_frame(1'b0, k);
    t = 0;
    while (q4_cyc.size() < pb + NUM_WORDS && t < 200) begin @(negedge clk); #1; t++; end
    start4 = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    k2 = cyc;
    start4 = 1'b0;
    n_vec++;
    if (d4_cyc.size() <= db || d4_cyc[db] != k + 1 + 17 * 4 + 1 || k2 != d4_cyc[db] + 1) begin
      n_err++;
      $display("FAIL held_start_done: dones=%0d relaunch_edge=%0d want done %0d then %0d",
               d4_cyc.size() - db, k2, k + 70, k + 71);
    end
    check_frame(1'b0, 4, k2, ref_buf, pb + NUM_WORDS, db + 1, b4, "held");
  endtask

  task automatic test_collision();
    int pb, db, bb, k;
    frame_t exp;
    wr(17, 16'h1234);
    exp = ref_buf;
    get_bases(1'b0, pb, db, bb);
    start_frame(1'b0, k);
    wr_en = 1'b1; wr_addr = 5'd17; wr_data = 16'hBEEF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    wr_en = 1'b1; wr_addr = 5'd17; wr_data = 16'hBEEF;
    @(posedge clk); #1;
    wr_en = 1'b0;
    ref_buf[17] = 16'hBEEF;
    check_frame(1'b0, 4, k, exp, pb, db, bb, "collide");
    wr(18, 16'hDEAD);
    wr(31, 16'hCAFE);
    get_bases(1'b0, pb, db, bb);
    start_frame(1'b0, k);
    check_frame(1'b0, 4, k, ref_buf, pb, db, bb, "after_collide");
  endtask

  task automatic test_reset_midframe();
    int pb, db, bb, k, t;
    get_bases(1'b0, pb, db, bb);
    start_frame(1'b0, k);
    t = 0;
    while (q4_cyc.size() < pb + 7 && t < 200) begin @(negedge clk); #1; t++; end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy4, done4, en4, data4} !== '0) begin
      n_err++;
      $display("FAIL midframe_reset: got busy=%b done=%b en=%b data=%04h want all 0",
               busy4, done4, en4, data4);
    end
    $display("reset asserted after %0d pulses", q4_cyc.size() - pb);
    for (int i = 0; i < NUM_WORDS; i++) ref_buf[i] = '0;
    @(negedge clk); rst_n = 1'b1;
    get_bases(1'b0, pb, db, bb);
    start_frame(1'b0, k);
    check_frame(1'b0, 4, k, ref_buf, pb, db, bb, "post_reset");
  endtask

  initial begin
    for (int i = 0; i < NUM_WORDS; i++) ref_buf[i] = '0;
    test_reset();
    test_zero_frame();
    test_ramp_frame();
    test_pace1();
    test_restart();
    test_collision();
    test_random();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation exceeded time limit, got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
